// File: rtl/arbiter_stream_mux.sv
// Packet-locked N:1 stream mux in front of a round-robin arbiter; first beat reaches out_* 3 cycles after request.
// Back-pressure: only the owner gets in_ready, gated by the output register (~out_valid | out_ready).
module arbiter_stream_mux #(
    parameter int NUM_PORTS  = 6,
    parameter int DATA_WIDTH = 32,
    localparam int SEL_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            request,
    input  logic [NUM_PORTS-1:0]            grant,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic                            active,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]            state;
    logic [SEL_WIDTH-1:0]  owner;
    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  sel_hit;
    logic                  out_free;
    logic                  transfer;

    assign out_free = ~out_valid | out_ready;
    assign transfer = (state == BUSY) & own_valid & out_free;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (owner == SEL_WIDTH'(p)) begin
                own_valid = in_valid[p];
                own_last  = in_last[p];
                own_data  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Owner's request stays up through gaps, and drops for the RELEASE cycle so the token moves on.
    always_comb begin
        request  = '0;
        in_ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            request[p]  = in_valid[p] | ((state == BUSY) && (owner == SEL_WIDTH'(p)));
            if ((state == RELEASE) && (owner == SEL_WIDTH'(p)))
                request[p] = 1'b0;
            in_ready[p] = (state == BUSY) && (owner == SEL_WIDTH'(p)) && out_free;
        end
        if (rst) begin
            request  = '0;
            in_ready = '0;
        end
    end

    // Grants to ports that are no longer requesting are stale and ignored.
    always_comb begin
        sel_hit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel == SEL_WIDTH'(p))
                sel_hit = grant[p] & request[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active && sel_hit) begin
                        owner <= sel;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (transfer && own_last)
                        state <= RELEASE;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (transfer) begin
                out_data  <= own_data;
                out_last  <= own_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arbiter_stream_mux.sv
// Directed bench for arbiter_stream_mux with a registered round-robin arbiter model in the loop.
module tb_arbiter_stream_mux;
    localparam int NP = 6;
    localparam int DW = 32;

    logic           clk;
    logic           rst;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]  in_valid;
    logic [NP-1:0]  in_last;
    logic [NP-1:0]  in_ready;
    logic [NP-1:0]  request;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;

    logic [NP-1:0]  a_grant;
    logic [2:0]     a_sel;
    logic           a_active;
    logic [2:0]     a_nxt;
    logic           a_fnd;

    arbiter_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .request(request), .grant(a_grant), .sel(a_sel), .active(a_active),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter model: keeps the grant while the holder requests, else next requester after the token.
    always_comb begin
        a_fnd = 1'b0;
        a_nxt = a_sel;
        for (int k = NP; k >= 1; k--) begin
            if (request[(int'(a_sel) + k) % NP]) begin
                a_fnd = 1'b1;
                a_nxt = 3'((int'(a_sel) + k) % NP);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grant  <= '0;
            a_sel    <= 3'(NP - 1);
            a_active <= 1'b0;
        end else if (!(a_active && request[a_sel])) begin
            if (a_fnd) begin
                a_sel    <= a_nxt;
                a_grant  <= 6'b1 << a_nxt;
                a_active <= 1'b1;
            end else begin
                a_grant  <= '0;
                a_active <= 1'b0;
            end
        end
    end

    logic [32:0]   srcq [NP][$];
    logic [NP-1:0] hold;
    logic [NP-1:0] acc;
    logic          ordy;
    logic [32:0]   olog [$];
    int            ocyc [$];
    logic [32:0]   ebeat [$];
    int            ecyc [$];
    logic [NP-1:0] reqh [64];
    int            cnum;
    int            n_chk;
    int            n_bad;
    int            stab_err, rdy_err, stalls;
    logic          pv, pr, pl;
    logic [DW-1:0] pd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic pkt(input int p, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            srcq[p].push_back({(i == n - 1), base + 32'(i)});
    endtask

    task automatic expb(input logic [31:0] d, input logic l, input int c);
        ebeat.push_back({l, d});
        if (c >= 0) ecyc.push_back(c);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_count"}, olog.size(), ebeat.size());
        for (int i = 0; i < ebeat.size() && i < olog.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), olog[i], ebeat[i]);
            if (ecyc.size() > i)
                chk($sformatf("%s_cyc%0d", tag, i), ocyc[i], ecyc[i]);
        end
    endtask

    // One cycle: drive after the edge, sample 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
            in_valid[p]          = (srcq[p].size() > 0) && !hold[p];
            in_last[p]           = (srcq[p].size() > 0) ? srcq[p][0][32] : 1'b0;
            in_data[p*DW +: DW]  = (srcq[p].size() > 0) ? srcq[p][0][31:0] : '0;
        end
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        if (cnum < 64) reqh[cnum] = request;
        if (out_valid && out_ready) begin
            olog.push_back({out_last, out_data});
            ocyc.push_back(cnum);
        end
        if (pv && !pr && !(out_valid && out_data == pd && out_last == pl)) stab_err++;
        if (out_valid && !out_ready) begin
            stalls++;
            if (in_ready != '0) rdy_err++;
        end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        cnum++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) srcq[p].delete();
        hold = '0; acc = '0; in_valid = '0; in_last = '0; in_data = '0;
        ordy = 1'b1; out_ready = 1'b1;
        olog.delete(); ocyc.delete(); ebeat.delete(); ecyc.delete();
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        stab_err = 0; rdy_err = 0; stalls = 0; cnum = 0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        logic [11:0] h;
        int gap_hi;
        n_chk = 0; n_bad = 0;
        rst = 1'b0; hold = '0; acc = '0; ordy = 1'b1; out_ready = 1'b1;
        in_valid = '0; in_last = '0; in_data = '0;
        #2 rst = 1'b1;
        in_valid = 6'h3F;
        #2;
        chk("rst_request", request, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);

        // Single 4-beat packet on port 2.
        do_reset();
        pkt(2, 32'hA0, 4);
        run(10);
        chk("t1_req_c0", reqh[0], 6'b000100);
        chk("t1_req2_c5", reqh[5][2], 1);
        chk("t1_req2_release", reqh[6][2], 0);
        expb(32'hA0, 0, 3); expb(32'hA1, 0, 4); expb(32'hA2, 0, 5); expb(32'hA3, 1, 6);
        chk_out("t1");

        // Three simultaneous packets: round-robin order 0, 1, 3.
        do_reset();
        pkt(0, 32'h10, 2); pkt(1, 32'h20, 2); pkt(3, 32'h30, 2);
        run(16);
        expb(32'h10, 0, 3);  expb(32'h11, 1, 4);
        expb(32'h20, 0, 7);  expb(32'h21, 1, 8);
        expb(32'h30, 0, 11); expb(32'h31, 1, 12);
        chk_out("t2");

        // Port 4 stalls 5 cycles mid-packet while port 5 waits.
        do_reset();
        pkt(4, 32'h40, 3); pkt(5, 32'h50, 1);
        gap_hi = 0;
        for (int c = 0; c < 16; c++) begin
            hold[4] = (c >= 3 && c < 8);
            cyc();
            if (c >= 3 && c < 8 && request[4]) gap_hi++;
        end
        chk("t3_req4_held", gap_hi, 5);
        expb(32'h40, 0, 3); expb(32'h41, 0, 9); expb(32'h42, 1, 10); expb(32'h50, 1, 13);
        chk_out("t3");

        // 8-beat packet with out_ready toggling 1,0,0,1.
        do_reset();
        pkt(0, 32'h60, 8);
        for (int c = 0; c < 30; c++) begin
            ordy = ((cnum % 4) == 0) || ((cnum % 4) == 3);
            cyc();
        end
        for (int i = 0; i < 8; i++) expb(32'h60 + 32'(i), (i == 7), -1);
        chk_out("t4");
        chk("t4_stable_err", stab_err, 0);
        chk("t4_ready_err", rdy_err, 0);
        chk("t4_stalls_seen", (stalls > 0), 1);

        // Port 1 alone, three 1-beat packets.
        do_reset();
        pkt(1, 32'h71, 1); pkt(1, 32'h72, 1); pkt(1, 32'h73, 1);
        run(14);
        for (int c = 0; c < 12; c++) h[c] = reqh[c][1];
        chk("t5_req1_hist", h, 12'h777);
        expb(32'h71, 1, 3); expb(32'h72, 1, 7); expb(32'h73, 1, 11);
        chk_out("t5");

        // Asynchronous reset mid-packet, then a clean packet from port 5.
        do_reset();
        pkt(3, 32'h90, 4);
        run(4);
        chk("t6_pre_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_in_ready", in_ready, 0);
        chk("t6_async_request", request, 0);
        chk("t6_async_data", out_data, 0);
        do_reset();
        pkt(5, 32'h80, 2);
        run(10);
        expb(32'h80, 0, 3); expb(32'h81, 1, 4);
        chk_out("t6");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
